icb2apb_bridge_n: RTL and testbench

- Parametrised ICB-slave to N-port APB-master bridge; successor to the fixed four-port bridge.
- Accepts one ICB command at a time and decodes the target APB port from the address.
- Runs a standard APB SETUP/ACCESS transfer with wait states and error reporting, then returns the ICB response.
- Sits between the ICB interconnect and the peripheral APB segments; verification wraps it like the existing top.

---
 rtl/icb2apb_pkg.sv | 28 ++
 rtl/icb2apb_decode.sv | 25 ++
 rtl/icb2apb_bridge_n.sv | 221 ++++++++++++++++++++++
 tb/tb_icb2apb_bridge_n.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb2apb_pkg.sv
// Shared types, default parameters and width helper for the ICB-to-APB bridge.
// Optional ACCESS watchdog in the top is enabled by defining ICB2APB_TIMEOUT_EN.
package icb2apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int DEF_NUM_APB        = 4;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_SEL_LSB        = 24;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // ceil(log2(n)), never less than 1 so a single-port build still has a select bit
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/icb2apb_decode.sv
// Port-select decode: extracts the APB port index from the ICB address and
// flags indices that do not map to an existing port.
module icb2apb_decode
    import icb2apb_pkg::*;
#(
    parameter int NUM_APB = DEF_NUM_APB,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int SEL_LSB = DEF_SEL_LSB,
    parameter int SEL_W   = sel_width(DEF_NUM_APB)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  idx,
    output logic              dec_err
);

    localparam logic [SEL_W:0] NUM_PORTS = (SEL_W + 1)'(NUM_APB);

    // only the select field matters here; the full address is latched by the FSM
    logic unused_addr;
    assign unused_addr = ^addr;

    assign idx     = addr[SEL_LSB +: SEL_W];
    assign dec_err = ({1'b0, idx} >= NUM_PORTS);

endmodule

// File: rtl/icb2apb_bridge_n.sv
// ICB slave to N-port APB master bridge: one outstanding command, SETUP/ACCESS
// transfer with wait states, ICB response held until accepted.
// Define ICB2APB_TIMEOUT_EN to abort ACCESS phases after TIMEOUT_CYCLES cycles.
module icb2apb_bridge_n
    import icb2apb_pkg::*;
#(
    parameter int NUM_APB        = DEF_NUM_APB,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SEL_LSB        = DEF_SEL_LSB,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      icb_cmd_valid,
    output logic                      icb_cmd_ready,
    input  logic [ADDR_W-1:0]         icb_cmd_addr,
    input  logic                      icb_cmd_read,
    input  logic [DATA_W-1:0]         icb_cmd_wdata,
    input  logic [DATA_W/8-1:0]       icb_cmd_wmask,
    output logic                      icb_rsp_valid,
    input  logic                      icb_rsp_ready,
    output logic [DATA_W-1:0]         icb_rsp_rdata,
    output logic                      icb_rsp_err,
    output logic [ADDR_W-1:0]         apb_paddr,
    output logic                      apb_pwrite,
    output logic [DATA_W-1:0]         apb_pwdata,
    output logic [DATA_W/8-1:0]       apb_pstrb,
    output logic                      apb_penable,
    output logic [NUM_APB-1:0]        apb_psel,
    input  logic [NUM_APB*DATA_W-1:0] apb_prdata,
    input  logic [NUM_APB-1:0]        apb_pready,
    input  logic [NUM_APB-1:0]        apb_pslverr
);

    localparam int SEL_W  = sel_width(NUM_APB);
    localparam int MASK_W = DATA_W / 8;

    state_e              state_reg, state_next;
    logic [NUM_APB-1:0]  psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic [ADDR_W-1:0]   paddr_reg, paddr_next;
    logic                pwrite_reg, pwrite_next;
    logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
    logic [MASK_W-1:0]   pstrb_reg, pstrb_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg, rsp_err_next;

    logic [SEL_W-1:0]    dec_idx;
    logic                dec_err;
    logic [NUM_APB-1:0]  dec_onehot;
    logic [DATA_W-1:0]   prdata_masked [NUM_APB];
    logic [DATA_W-1:0]   prdata_sel;
    logic                pready_sel;
    logic                pslverr_sel;
    logic                tmo_hit;

    icb2apb_decode #(
        .NUM_APB (NUM_APB),
        .ADDR_W  (ADDR_W),
        .SEL_LSB (SEL_LSB),
        .SEL_W   (SEL_W)
    ) u_decode (
        .addr    (icb_cmd_addr),
        .idx     (dec_idx),
        .dec_err (dec_err)
    );

    // psel_reg is one-hot during a transfer, so it doubles as the return-path mux select
    for (genvar gi = 0; gi < NUM_APB; gi++) begin : g_port
        assign dec_onehot[gi]    = !dec_err && (dec_idx == SEL_W'(gi));
        assign prdata_masked[gi] = psel_reg[gi] ? apb_prdata[gi*DATA_W +: DATA_W] : '0;
    end

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NUM_APB; i++) begin
            prdata_sel = prdata_sel | prdata_masked[i];
        end
    end

    assign pready_sel  = |(apb_pready & psel_reg);
    assign pslverr_sel = |(apb_pslverr & psel_reg);

`ifdef ICB2APB_TIMEOUT_EN
    localparam int TMO_W = sel_width(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    // counts ACCESS cycles that ended without pready; a late pready on the last cycle still wins
    always_comb begin
        tmo_cnt_next = tmo_cnt_reg;
        if (state_reg == ST_SETUP) begin
            tmo_cnt_next = '0;
        end else if ((state_reg == ST_ACCESS) && !pready_sel) begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
    end

    assign tmo_hit = (state_reg == ST_ACCESS) && !pready_sel &&
                     (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        paddr_next     = paddr_reg;
        pwrite_next    = pwrite_reg;
        pwdata_next    = pwdata_reg;
        pstrb_next     = pstrb_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (icb_cmd_valid) begin
                    if (dec_err) begin
                        state_next     = ST_RESP;
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = '0;
                        rsp_err_next   = 1'b1;
                    end else begin
                        state_next   = ST_SETUP;
                        psel_next    = dec_onehot;
                        penable_next = 1'b0;
                        paddr_next   = icb_cmd_addr;
                        pwrite_next  = !icb_cmd_read;
                        pwdata_next  = icb_cmd_wdata;
                        pstrb_next   = icb_cmd_read ? '0 : icb_cmd_wmask;
                    end
                end
            end
            ST_SETUP: begin
                state_next   = ST_ACCESS;
                penable_next = 1'b1;
            end
            ST_ACCESS: begin
                if (pready_sel) begin
                    state_next     = ST_RESP;
                    psel_next      = '0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = pwrite_reg ? '0 : prdata_sel;
                    rsp_err_next   = pslverr_sel;
                end else if (tmo_hit) begin
                    state_next     = ST_RESP;
                    psel_next      = '0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                end
            end
            ST_RESP: begin
                if (icb_rsp_ready) begin
                    state_next     = ST_IDLE;
                    rsp_valid_next = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            paddr_reg     <= paddr_next;
            pwrite_reg    <= pwrite_next;
            pwdata_reg    <= pwdata_next;
            pstrb_reg     <= pstrb_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    // gated by rst_n so that every output reads 0 while reset is held
    assign icb_cmd_ready = rst_n && (state_reg == ST_IDLE);
    assign icb_rsp_valid = rsp_valid_reg;
    assign icb_rsp_rdata = rsp_rdata_reg;
    assign icb_rsp_err   = rsp_err_reg;
    assign apb_paddr     = paddr_reg;
    assign apb_pwrite    = pwrite_reg;
    assign apb_pwdata    = pwdata_reg;
    assign apb_pstrb     = pstrb_reg;
    assign apb_penable   = penable_reg;
    assign apb_psel      = psel_reg;

endmodule

// File: tb/tb_icb2apb_bridge_n.sv
// Self-checking bench for icb2apb_bridge_n (3 APB ports, so select value 3 is a decode error).
// Expected latency/data come from the transfer rules; timeout cases run when ICB2APB_TIMEOUT_EN is set.
module tb_icb2apb_bridge_n;

    localparam int NUM_APB = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = DATA_W / 8;
    localparam int SEL_LSB = 24;
    localparam int TMO     = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      icb_cmd_valid;
    logic                      icb_cmd_ready;
    logic [ADDR_W-1:0]         icb_cmd_addr;
    logic                      icb_cmd_read;
    logic [DATA_W-1:0]         icb_cmd_wdata;
    logic [MASK_W-1:0]         icb_cmd_wmask;
    logic                      icb_rsp_valid;
    logic                      icb_rsp_ready;
    logic [DATA_W-1:0]         icb_rsp_rdata;
    logic                      icb_rsp_err;
    logic [ADDR_W-1:0]         apb_paddr;
    logic                      apb_pwrite;
    logic [DATA_W-1:0]         apb_pwdata;
    logic [MASK_W-1:0]         apb_pstrb;
    logic                      apb_penable;
    logic [NUM_APB-1:0]        apb_psel;
    logic [NUM_APB*DATA_W-1:0] apb_prdata = '0;
    logic [NUM_APB-1:0]        apb_pready = '0;
    logic [NUM_APB-1:0]        apb_pslverr = '0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wait_cfg  [NUM_APB];
    bit          err_cfg   [NUM_APB];
    logic [31:0] rdata_cfg [NUM_APB];
    int          acc_cnt   [NUM_APB];

    always #5 clk = ~clk;

    icb2apb_bridge_n #(
        .NUM_APB        (NUM_APB),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .SEL_LSB        (SEL_LSB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .apb_paddr     (apb_paddr),
        .apb_pwrite    (apb_pwrite),
        .apb_pwdata    (apb_pwdata),
        .apb_pstrb     (apb_pstrb),
        .apb_penable   (apb_penable),
        .apb_psel      (apb_psel),
        .apb_prdata    (apb_prdata),
        .apb_pready    (apb_pready),
        .apb_pslverr   (apb_pslverr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // APB slaves: a selected port answers after wait_cfg ACCESS cycles; otherwise lines carry noise
    always @(negedge clk) begin
        for (int p = 0; p < NUM_APB; p++) begin
            if (apb_psel[p] && apb_penable) begin
                if (acc_cnt[p] >= wait_cfg[p]) begin
                    apb_pready[p]                     = 1'b1;
                    apb_pslverr[p]                    = err_cfg[p];
                    apb_prdata[p*DATA_W +: DATA_W]    = rdata_cfg[p];
                end else begin
                    apb_pready[p]                     = 1'b0;
                    apb_pslverr[p]                    = 1'($urandom);
                    apb_prdata[p*DATA_W +: DATA_W]    = $urandom;
                end
                acc_cnt[p]++;
            end else begin
                acc_cnt[p]                            = 0;
                apb_pready[p]                         = 1'($urandom);
                apb_pslverr[p]                        = 1'($urandom);
                apb_prdata[p*DATA_W +: DATA_W]        = $urandom;
            end
        end
    end

    task automatic do_txn(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                          input logic [3:0] wm, input int waits, input bit serr,
                          input logic [31:0] rdv, input int hold);
        int          port;
        bit          derr;
        int          exp_lat;
        int          exp_acc;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          n;
        int          acc_seen;
        bit          bad_apb;
        bit          bad_ready;
        bit          bad_hold;

        port = int'(addr[SEL_LSB +: 2]);
        derr = (port >= NUM_APB);
        if (!derr) begin
            wait_cfg[port]  = waits;
            err_cfg[port]   = serr;
            rdata_cfg[port] = rdv;
        end

        if (derr) begin
            exp_lat = 1; exp_acc = 0; exp_rdata = '0; exp_err = 1'b1;
        end
`ifdef ICB2APB_TIMEOUT_EN
        else if (waits >= TMO) begin
            exp_lat = 2 + TMO; exp_acc = TMO; exp_rdata = '0; exp_err = 1'b1;
        end
`endif
        else begin
            exp_lat   = 3 + waits;
            exp_acc   = waits + 1;
            exp_rdata = rd ? rdv : 32'h0;
            exp_err   = serr;
        end

        check_val("cmd_ready_idle", 32'(icb_cmd_ready), 32'd1);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        icb_rsp_ready = 1'b0;
        @(negedge clk);
        icb_cmd_valid = 1'b0;

        n = 1; acc_seen = 0; bad_apb = 1'b0; bad_ready = 1'b0;
        while (icb_rsp_valid !== 1'b1 && n <= exp_lat + 20) begin
            if (n == 1 && !derr) begin
                check_val("setup_psel",    32'(apb_psel),    32'(1) << port);
                check_val("setup_penable", 32'(apb_penable), 32'd0);
                check_val("setup_paddr",   apb_paddr,        addr);
                check_val("setup_pwrite",  32'(apb_pwrite),  32'(!rd));
                check_val("setup_pwdata",  apb_pwdata,       wd);
                check_val("setup_pstrb",   32'(apb_pstrb),   32'(rd ? 4'h0 : wm));
            end
            if ($countones(apb_psel) > 1 || (apb_penable && apb_psel == '0) ||
                (derr && apb_psel != '0) ||
                (!derr && apb_psel != '0 && 32'(apb_psel) != (32'(1) << port)))
                bad_apb = 1'b1;
            if (icb_cmd_ready) bad_ready = 1'b1;
            if (apb_penable) acc_seen++;
            @(negedge clk);
            n++;
        end

        check_val("rsp_latency",   32'(n),             32'(exp_lat));
        check_val("rsp_valid",     32'(icb_rsp_valid), 32'd1);
        check_val("rsp_rdata",     icb_rsp_rdata,      exp_rdata);
        check_val("rsp_err",       32'(icb_rsp_err),   32'(exp_err));
        check_val("access_cycles", 32'(acc_seen),      32'(exp_acc));
        check_val("apb_protocol",  32'(bad_apb),       32'd0);
        check_val("busy_not_ready", 32'(bad_ready),    32'd0);
        check_val("rsp_psel_low",  32'({apb_psel, apb_penable}), 32'd0);

        // offer a competing command while the response is stalled; it must be ignored
        bad_hold      = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h0;
        icb_cmd_read  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== exp_rdata ||
                icb_rsp_err !== exp_err || icb_cmd_ready !== 1'b0 || apb_psel != '0)
                bad_hold = 1'b1;
        end
        check_val("rsp_hold_stable", 32'(bad_hold), 32'd0);

        icb_rsp_ready = 1'b1;
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b0;
        check_val("post_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        check_val("post_psel",      32'(apb_psel),      32'd0);
        check_val("post_cmd_ready", 32'(icb_cmd_ready), 32'd1);

        $display("[TB] txn addr=%08h %s port=%0d waits=%0d hold=%0d lat=%0d err=%0b rdata=%08h",
                 addr, rd ? "RD" : "WR", port, waits, hold, n, icb_rsp_err, icb_rsp_rdata);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          port;
        int          max_wait;

        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b0;
        for (int p = 0; p < NUM_APB; p++) begin
            wait_cfg[p] = 0; err_cfg[p] = 1'b0; rdata_cfg[p] = '0;
        end

        repeat (3) @(negedge clk);
        check_val("reset_psel",      32'(apb_psel),      32'd0);
        check_val("reset_penable",   32'(apb_penable),   32'd0);
        check_val("reset_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        check_val("reset_cmd_ready", 32'(icb_cmd_ready), 32'd0);
        check_val("reset_paddr",     apb_paddr,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(32'h0200_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
        do_txn(32'h0100_0004, 1'b1, 32'h0,         4'h0, 3, 1'b0, 32'h1234_5678, 0);
        do_txn(32'h0300_0000, 1'b1, 32'h0,         4'h0, 0, 1'b0, 32'h0, 1);
        do_txn(32'h0000_0020, 1'b1, 32'h0,         4'h0, 1, 1'b1, 32'hCAFE_F00D, 5);
        do_txn(32'h0200_0044, 1'b0, 32'h0BAD_F00D, 4'h5, 2, 1'b1, 32'h0, 2);

        // reset asserted mid-ACCESS: outputs clear immediately, then a normal command completes
        wait_cfg[1]   = 50;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h0100_0008;
        icb_cmd_read  = 1'b1;
        @(negedge clk);
        icb_cmd_valid = 1'b0;
        @(negedge clk);
        check_val("rst_pre_penable", 32'(apb_penable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_async_psel",      32'(apb_psel),      32'd0);
        check_val("rst_async_penable",   32'(apb_penable),   32'd0);
        check_val("rst_async_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        check_val("rst_async_cmd_ready", 32'(icb_cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_release_ready", 32'(icb_cmd_ready), 32'd1);
        $display("[TB] txn mid-access reset");
        do_txn(32'h0100_0010, 1'b1, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_5A5A, 0);

`ifdef ICB2APB_TIMEOUT_EN
        do_txn(32'h0000_0000, 1'b1, 32'h0, 4'h0, TMO - 1, 1'b0, 32'h7777_0001, 0);
        do_txn(32'h0100_0000, 1'b1, 32'h0, 4'h0, TMO,     1'b0, 32'h7777_0002, 1);
        do_txn(32'h0200_0000, 1'b0, 32'h1, 4'h3, 20,      1'b0, 32'h0, 0);
        max_wait = TMO + 2;
`else
        max_wait = 4;
`endif

        for (int t = 0; t < 40; t++) begin
            port = int'($urandom_range(0, 3));
            a    = $urandom;
            a[SEL_LSB +: 2] = 2'(port);
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, max_wait)),
                   1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
